// File: rtl/decoder_pipelined.sv
// decoder_pipelined: splits fetch bundles into decoded lanes, buffers them in a 2-entry skid FIFO, returns fetcher feedback.
// Ports: clk_i/rst_ni (sync active-low), flush_i, warp_start_i; ic_* fetch bundle in, dec_ready_o back-pressure;
// dec_* FIFO head to dispatch with disp_ready_i; fb_* registered feedback one cycle after each acceptance; warp_stopped_o.
// Opcode byte: [7:4] class (0 IU, 1 FPU, 2 LSU, 3 cond branch), [3:0] subtype; IU subtype[3]=1 immediate,
// FPU subtypes 8..12 unary, LSU subtype[0]=1 store; 0x40 STOP, 0x41 JMP, 0x42 SYNC; other classes have no register operands.
module decoder_pipelined #(
  parameter int FetchWidth = 2,
  parameter int PcWidth = 32,
  parameter int NumWarps = 8,
  parameter int WarpWidth = 32,
  parameter int OperandsPerInst = 2,
  localparam int EncInstWidth = 16 + 8 * OperandsPerInst,
  localparam int WidW = $clog2(NumWarps),
  localparam int SwidW = $clog2(WarpWidth)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [NumWarps-1:0]                     warp_start_i,
  output logic                                    dec_ready_o,
  input  logic [FetchWidth-1:0]                   ic_valid_i,
  input  logic [FetchWidth-1:0]                   ic_fetch_mask_i,
  input  logic [PcWidth-1:0]                      ic_pc_i,
  input  logic [WarpWidth-1:0]                    ic_act_mask_i,
  input  logic [WidW-1:0]                         ic_warp_id_i,
  input  logic [SwidW-1:0]                        ic_subwarp_id_i,
  input  logic [FetchWidth*EncInstWidth-1:0]      ic_inst_i,
  input  logic                                    disp_ready_i,
  output logic [FetchWidth-1:0]                   dec_valid_o,
  output logic [PcWidth-1:0]                      dec_pc_o,
  output logic [WarpWidth-1:0]                    dec_act_mask_o,
  output logic [WidW-1:0]                         dec_warp_id_o,
  output logic [SwidW-1:0]                        dec_subwarp_id_o,
  output logic [FetchWidth*8-1:0]                 dec_inst_o,
  output logic [FetchWidth*8-1:0]                 dec_dst_o,
  output logic [FetchWidth*OperandsPerInst-1:0]   dec_operands_is_reg_o,
  output logic [FetchWidth*OperandsPerInst*8-1:0] dec_operands_o,
  output logic                                    fb_valid_o,
  output logic                                    fb_stop_o,
  output logic                                    fb_branch_o,
  output logic                                    fb_sync_o,
  output logic [FetchWidth-1:0]                   fb_unused_ibe_o,
  output logic [WidW-1:0]                         fb_warp_id_o,
  output logic [SwidW-1:0]                        fb_subwarp_id_o,
  output logic [PcWidth-1:0]                      fb_next_pc_o,
  output logic [NumWarps-1:0]                     warp_stopped_o
);
  localparam int EntW = FetchWidth * (17 + 9 * OperandsPerInst) + PcWidth + WarpWidth + WidW + SwidW;
  localparam logic [7:0] OpStop = 8'h40, OpJmp = 8'h41, OpSync = 8'h42;
  localparam logic [3:0] ClsIu = 4'h0, ClsFpu = 4'h1, ClsLsu = 4'h2, ClsBr = 4'h3;

  function automatic logic op_is_reg(input logic [7:0] op, input int k);
    logic fpu, un;
    fpu = op[7:4] == ClsFpu;
    un = fpu && op[3:0] >= 4'd8 && op[3:0] <= 4'd12;
    return k >= 2 ? fpu && !un :
           op[7:4] == ClsIu ? !op[3] || k == 1 :
           fpu ? !un || k == 0 :
           op[7:4] == ClsLsu ? k == 1 || op[0] :
           op[7:4] == ClsBr && k == 1;
  endfunction

  logic [FetchWidth-1:0]                   w_valid;
  logic                                    w_stop, w_branch, w_sync, w_jmp, w_done;
  logic [PcWidth-1:0]                      w_cnt, w_jmp_pc;
  logic [FetchWidth*8-1:0]                 w_inst, w_dst;
  logic [FetchWidth*OperandsPerInst-1:0]   w_isreg;
  logic [FetchWidth*OperandsPerInst*8-1:0] w_ops;

  // Lanes decode in order; a branch or control op ends the bundle and later lanes are dropped.
  always_comb begin
    logic [7:0] op;
    op = '0;
    w_valid = '0;
    w_stop = 1'b0;
    w_branch = 1'b0;
    w_sync = 1'b0;
    w_jmp = 1'b0;
    w_done = 1'b0;
    w_cnt = '0;
    w_jmp_pc = '0;
    w_inst = '0;
    w_dst = '0;
    w_isreg = '0;
    w_ops = '0;
    for (int f = 0; f < FetchWidth; f++) begin
      op = ic_inst_i[f*EncInstWidth+EncInstWidth-8 +: 8];
      w_inst[f*8 +: 8] = op;
      w_dst[f*8 +: 8] = ic_inst_i[f*EncInstWidth+EncInstWidth-16 +: 8];
      for (int k = 0; k < OperandsPerInst; k++) begin
        w_ops[(f*OperandsPerInst+k)*8 +: 8] = ic_inst_i[f*EncInstWidth+k*8 +: 8];
        w_isreg[f*OperandsPerInst+k] = op_is_reg(op, k);
      end
      if (ic_valid_i[f] && !w_done) begin
        w_cnt = w_cnt + PcWidth'(1);
        w_valid[f] = !(op == OpStop || op == OpJmp || op == OpSync);
        w_stop = w_stop || op == OpStop;
        w_sync = w_sync || op == OpSync;
        w_branch = w_branch || op[7:4] == ClsBr;
        if (op == OpJmp) begin
          w_jmp = 1'b1;
          w_jmp_pc = ic_pc_i + PcWidth'(f + 1) + PcWidth'($signed(ic_inst_i[f*EncInstWidth +: 16]));
        end
        w_done = !w_valid[f] || op[7:4] == ClsBr;
      end
    end
  end

  logic [EntW-1:0]     r_mem [2];
  logic [1:0]          r_cnt;
  logic                r_rd, r_ready;
  logic [NumWarps-1:0] r_stopped;
  logic                r_fb_valid, r_fb_stop, r_fb_branch, r_fb_sync;
  logic [FetchWidth-1:0] r_fb_unused;
  logic [WidW-1:0]     r_fb_wid;
  logic [SwidW-1:0]    r_fb_swid;
  logic [PcWidth-1:0]  r_fb_npc;
  logic [FetchWidth-1:0] w_hvalid;
  logic                w_wstop, w_accept, w_push, w_pop, w_wr, w_take;
  logic [1:0]          w_cnt_nxt;

  assign w_wstop = r_stopped[ic_warp_id_i];
  assign w_accept = |ic_valid_i && r_ready;
  assign w_take = w_accept && !w_wstop;
  assign w_push = w_take && |w_valid && !flush_i;
  assign w_pop = r_cnt != 2'd0 && disp_ready_i && !flush_i;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);
  assign w_wr = r_rd ^ r_cnt[0];

  always_ff @(posedge clk_i)
    if (w_push) r_mem[w_wr] <= {w_valid, ic_pc_i, ic_act_mask_i, ic_warp_id_i, ic_subwarp_id_i, w_inst, w_dst, w_isreg, w_ops};

  // Ready is registered from the post-update occupancy, so a push can never land on a full FIFO.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_rd <= 1'b0;
      r_ready <= 1'b0;
    end else if (flush_i) begin
      r_cnt <= '0;
      r_rd <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rd <= r_rd ^ w_pop;
      r_ready <= w_cnt_nxt <= 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stopped <= '0;
      r_fb_valid <= 1'b0;
      r_fb_stop <= 1'b0;
      r_fb_branch <= 1'b0;
      r_fb_sync <= 1'b0;
      r_fb_unused <= '0;
      r_fb_wid <= '0;
      r_fb_swid <= '0;
      r_fb_npc <= '0;
    end else begin
      r_stopped <= (r_stopped | (w_take && w_stop ? NumWarps'(1) << ic_warp_id_i : '0)) & ~warp_start_i;
      r_fb_valid <= w_accept;
      r_fb_stop <= w_take && w_stop;
      r_fb_branch <= w_take && w_branch;
      r_fb_sync <= w_take && w_sync;
      r_fb_unused <= !w_accept ? '0 : w_wstop ? ic_fetch_mask_i : ic_fetch_mask_i & ~w_valid;
      r_fb_wid <= ic_warp_id_i;
      r_fb_swid <= ic_subwarp_id_i;
      r_fb_npc <= w_wstop ? ic_pc_i : w_jmp ? w_jmp_pc : ic_pc_i + w_cnt;
    end
  end

  assign {w_hvalid, dec_pc_o, dec_act_mask_o, dec_warp_id_o, dec_subwarp_id_o,
          dec_inst_o, dec_dst_o, dec_operands_is_reg_o, dec_operands_o} = r_mem[r_rd];
  assign dec_valid_o = r_cnt != 2'd0 ? w_hvalid : '0;
  assign dec_ready_o = r_ready;
  assign warp_stopped_o = r_stopped;
  assign fb_valid_o = r_fb_valid;
  assign fb_stop_o = r_fb_stop;
  assign fb_branch_o = r_fb_branch;
  assign fb_sync_o = r_fb_sync;
  assign fb_unused_ibe_o = r_fb_unused;
  assign fb_warp_id_o = r_fb_wid;
  assign fb_subwarp_id_o = r_fb_swid;
  assign fb_next_pc_o = r_fb_npc;
endmodule
